// File: rtl/noc_vc_bridge.sv
// Packet-level bridge from one NoC flit stream onto NUM_VC downstream virtual channels.
// A VC is allocated on each header flit and stays locked until its tail flit is handshaken.
module noc_vc_bridge #(
  parameter int DATA_W  = 32,
  parameter int NUM_VC  = 2,
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 8
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_flit,
  input  logic                     in_is_header,
  input  logic                     in_is_tail,
  output logic [NUM_VC-1:0]        out_valid,
  input  logic [NUM_VC-1:0]        out_ready,
  input  logic [NUM_VC-1:0]        out_vc_ready,
  output logic [NUM_VC*DATA_W-1:0] out_flit,
  output logic [NUM_VC-1:0]        out_is_header,
  output logic [NUM_VC-1:0]        out_is_tail,
  output logic                     busy,
  output logic [NUM_VC-1:0]        grant_vc,
  output logic                     drop_pulse,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [NUM_VC-1:0] grant_q, grant_d;
  logic [VC_W-1:0]   gidx_q, gidx_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [NUM_VC-1:0] alloc_oh;
  logic [VC_W-1:0]   alloc_idx;
  logic              alloc_found;
  int                alloc_base;
  int                alloc_pos;

  logic [NUM_VC-1:0] lock_sel;
  logic              fire;

  // Search starts at rr_ptr (round-robin) or at 0 (fixed priority) and wraps modulo NUM_VC.
  always_comb begin
    alloc_oh    = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    alloc_base  = (RR_MODE != 0) ? int'(rr_ptr_q) : 0;
    alloc_pos   = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      alloc_pos = alloc_base + i;
      if (alloc_pos >= NUM_VC) begin
        alloc_pos = alloc_pos - NUM_VC;
      end
      if (!alloc_found && out_vc_ready[alloc_pos]) begin
        alloc_found          = 1'b1;
        alloc_oh[alloc_pos]  = 1'b1;
        alloc_idx            = VC_W'(alloc_pos);
      end
    end
  end

  assign lock_sel = (state_q == ST_LOCKED) ? grant_q : '0;

  // In IDLE only stray body flits are accepted (and dropped); headers wait for allocation.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      in_ready = ~in_is_header;
    end else begin
      in_ready = |(grant_q & out_ready);
    end
  end

  assign fire = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !in_is_header) begin
          drop_pulse_d = 1'b1;
          if (drop_cnt_q != {CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end else if (in_valid && in_is_header && alloc_found) begin
          state_d = ST_LOCKED;
          grant_d = alloc_oh;
          gidx_d  = alloc_idx;
        end
      end
      ST_LOCKED: begin
        if (fire && in_is_tail) begin
          state_d = ST_IDLE;
          grant_d = '0;
          if (RR_MODE != 0) begin
            rr_ptr_d = (gidx_q == VC_W'(NUM_VC - 1)) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Zero-latency forwarding onto the locked VC; every other VC is held at zero.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc_out
    assign out_valid[gi]                   = lock_sel[gi] & in_valid;
    assign out_is_header[gi]               = lock_sel[gi] & in_is_header;
    assign out_is_tail[gi]                 = lock_sel[gi] & in_is_tail;
    assign out_flit[gi*DATA_W +: DATA_W]   = lock_sel[gi] ? in_flit : '0;
  end

  assign busy       = (state_q == ST_LOCKED);
  assign grant_vc   = grant_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/noc_vc_bridge.md
Name: noc_vc_bridge

Overview:
- Packet-level bridge between one NoC flit input and NUM_VC output virtual channels.
- Allocates a free VC per packet on its header flit and locks that VC until the tail flit is handshaken.
- Selects among VCs whose VCready is set, using either round-robin or fixed priority.
- Sits between a router input port and the per-VC input buffers of the downstream router; it generalises the earlier two-channel, fixed-priority bridge.

Parameters:
- DATA_W, 32: flit width in bits.
- NUM_VC, 2: number of output virtual channels, legal range 2..8.
- RR_MODE, 1: 1 = round-robin allocation; 0 = fixed priority, lowest index wins.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid && in_ready.
- in_flit  in  DATA_W  input flit.
- in_is_header  in  1  first flit of a packet.
- in_is_tail  in  1  last flit of a packet; may be set together with in_is_header.
- out_valid  out  NUM_VC  per-VC valid, bit v = VC v.
- out_ready  in  NUM_VC  per-VC flit ready.
- out_vc_ready  in  NUM_VC  per-VC "buffer free for a new packet"; sampled only at allocation.
- out_flit  out  NUM_VC*DATA_W  per-VC flit, slice v = [v*DATA_W +: DATA_W].
- out_is_header  out  NUM_VC  per-VC header flag.
- out_is_tail  out  NUM_VC  per-VC tail flag.
- busy  out  1  high while a VC is locked (state LOCKED).
- grant_vc  out  NUM_VC  one-hot locked VC; zero in IDLE.
- drop_pulse  out  1  one-cycle pulse when a stray flit is discarded.
- drop_cnt  out  CNT_W  saturating count of discarded flits.

Behaviour:
- Reset (async, noc_rst_n low) sets:
  - state IDLE; grant_vc 0; rr_ptr 0; busy 0.
  - drop_cnt 0; drop_pulse 0.
  - all out_valid 0, out_flit 0, out_is_header 0, out_is_tail 0.
- Reset asserted mid-packet: packet abandoned, block returns to IDLE at once. No tail is emitted.
- State IDLE:
  - Non-header flit with in_valid: in_ready=1, flit discarded, drop_pulse=1 on the next cycle, drop_cnt+1 saturating at 2^CNT_W-1. Stays IDLE.
  - Header flit with in_valid and no out_vc_ready bit set: in_ready=0, stall, no state change.
  - Header flit with in_valid and at least one out_vc_ready bit set: in_ready=0. At the next edge, grant_vc is registered and the state goes to LOCKED. The header is not consumed in IDLE.
- Allocation:
  - RR_MODE=1: first set out_vc_ready bit at or above rr_ptr, wrapping modulo NUM_VC.
  - RR_MODE=0: lowest set index.
- State LOCKED (granted VC g):
  - out_valid[g] = in_valid; out_flit, out_is_header and out_is_tail slices g = inputs; in_ready = out_ready[g].
  - All other VC outputs are held at 0, and out_ready of other VCs is ignored.
  - out_vc_ready is ignored, including deassertion mid-packet.
  - Handshake with in_is_tail=1: next state IDLE; grant_vc cleared; rr_ptr = (g+1) mod NUM_VC (RR_MODE=1 only).
  - A header flit arriving without a preceding tail is forwarded unchanged. The protocol error is not detected.
- Timing:
  - One bubble cycle per packet for allocation.
  - Header reaches the VC output one cycle after it first appears with a ready VC.
  - Forwarding datapath is combinational, zero latency in LOCKED.
- Single-flit packet (header and tail set together): allocate, forward one flit, return to IDLE; next packet allocatable on the following cycle.
- in_valid dropping mid-packet: VC stays locked, out_valid[g]=0.
- drop_pulse and drop_cnt update in the same cycle edge; drop_pulse is registered.

Test Plan:
- Reset, then 3-flit packet (header, body, tail) with out_vc_ready=2'b11, RR_MODE=1 -> grant_vc=2'b01, in_ready low for 1 cycle, flits appear on VC0 only, tail -> IDLE, rr_ptr=1.
- Second identical packet -> grant_vc=2'b10, data on VC1 slice only, VC0 outputs stay 0. Third packet -> back to VC0 (wrap).
- NUM_VC=4, RR_MODE=0, out_vc_ready=4'b1100 -> grant_vc=4'b0100 every packet; with 4'b0000, header stalls with in_ready=0 until 4'b1000 appears, then grant_vc=4'b1000.
- LOCKED on VC0 with out_ready[0] toggled 1,0,0,1 -> in_ready follows out_ready[0]. Deasserting out_vc_ready[0] mid-packet -> no effect.
- In IDLE, feed 300 body flits with CNT_W=8 -> 300 drop_pulses, drop_cnt saturates at 255, no out_valid. Then a single-flit packet (header and tail set) -> forwarded in 1 cycle after allocation, busy high exactly 1 cycle.
- Assert noc_rst_n low during flit 2 of 4 -> all outputs 0 immediately. After release, a new header allocates VC0.
